// File: rtl/alu_flags_pkg.sv
// Shared flag-stage definitions: condition codes, flag bit positions and the
// add/subtract opcode group also used by the ALU flag generators.
package alu_flags_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [2:0] OP_ADDSUB = 3'b100;

endpackage

// File: rtl/alu_status_register_cond_eval.sv
// Combinational condition-code evaluator: decides a 4-bit cond against {N,Z,C,V}.
module cond_eval
  import alu_flags_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       result_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    result_o = 1'b0;
    unique case (cond_e'(cond_i))
      COND_EQ: result_o = z;
      COND_NE: result_o = ~z;
      COND_CS: result_o = c;
      COND_CC: result_o = ~c;
      COND_MI: result_o = n;
      COND_PL: result_o = ~n;
      COND_VS: result_o = v;
      COND_VC: result_o = ~v;
      COND_HI: result_o = c & ~z;
      COND_LS: result_o = ~c | z;
      COND_GE: result_o = (n == v);
      COND_LT: result_o = (n != v);
      COND_GT: result_o = ~z & (n == v);
      COND_LE: result_o = z | (n != v);
      COND_AL: result_o = 1'b1;
      COND_NV: result_o = 1'b0;
      default: result_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_status_register.sv
// Architectural status register: latches ALU flags, tracks sticky overflow and a
// saturating overflow-event count, and registers a forwarded condition decision.
module alu_status_register
  import alu_flags_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_valid,
  input  logic [3:0]         control,
  input  logic               n_in,
  input  logic               z_in,
  input  logic               c_in,
  input  logic               v_in,
  input  logic               set_valid,
  input  logic [3:0]         set_flags,
  input  logic               sticky_clr,
  input  logic [3:0]         cond,
  output logic [3:0]         flags,
  output logic               v_sticky,
  output logic [COUNT_W-1:0] ovf_count,
  output logic               cond_true
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  logic [3:0]         flags_q, flags_d;
  logic               sticky_q, sticky_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               cond_q, cond_d;
  logic               is_addsub, ovf_evt;
  logic               unused_ctl;

  // Add and subtract share an opcode group; the direction bit does not matter here.
  assign is_addsub  = (control[3:1] == OP_ADDSUB);
  assign unused_ctl = control[0];
  assign ovf_evt    = alu_valid & ~set_valid & is_addsub & v_in;

  always_comb begin
    flags_d = flags_q;
    if (set_valid) begin
      flags_d = set_flags;
    end else if (alu_valid) begin
      flags_d[FLAG_N] = n_in;
      flags_d[FLAG_Z] = z_in;
      if (is_addsub) begin
        flags_d[FLAG_C] = c_in;
        flags_d[FLAG_V] = v_in;
      end
    end
  end

  // An event in the same cycle as a clear wins: it is the first event after the clear.
  always_comb begin
    sticky_d = ovf_evt | (sticky_q & ~sticky_clr);
    cnt_d    = cnt_q;
    if (sticky_clr)
      cnt_d = ovf_evt ? CNT_ONE : '0;
    else if (ovf_evt && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_ONE;
  end

  // Evaluate against next-state flags so a check right after a flag update sees it.
  cond_eval u_cond_eval (
    .cond_i   (cond),
    .flags_i  (flags_d),
    .result_o (cond_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q  <= 4'b0000;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      cond_q   <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      cond_q   <= cond_d;
    end
  end

  assign flags     = flags_q;
  assign v_sticky  = sticky_q;
  assign ovf_count = cnt_q;
  assign cond_true = cond_q;

endmodule

// File: tb/tb_alu_status_register.sv
// Directed vector bench; a second instance with a 2-bit counter exercises saturation.
module tb_alu_status_register;

  logic       clk = 1'b0;
  logic       rst_n, alu_valid, set_valid, sticky_clr;
  logic [3:0] control, nzcv, set_flags, cond;

  logic [3:0] flags_a, flags_b;
  logic       st_a, st_b, ct_a, ct_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  alu_status_register #(.COUNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .control(control),
    .n_in(nzcv[3]), .z_in(nzcv[2]), .c_in(nzcv[1]), .v_in(nzcv[0]),
    .set_valid(set_valid), .set_flags(set_flags), .sticky_clr(sticky_clr),
    .cond(cond), .flags(flags_a), .v_sticky(st_a), .ovf_count(cnt_a),
    .cond_true(ct_a)
  );

  alu_status_register #(.COUNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .control(control),
    .n_in(nzcv[3]), .z_in(nzcv[2]), .c_in(nzcv[1]), .v_in(nzcv[0]),
    .set_valid(set_valid), .set_flags(set_flags), .sticky_clr(sticky_clr),
    .cond(cond), .flags(flags_b), .v_sticky(st_b), .ovf_count(cnt_b),
    .cond_true(ct_b)
  );

  typedef struct {
    logic       rst_n;
    logic       alu_valid;
    logic [3:0] control;
    logic [3:0] nzcv;
    logic       set_valid;
    logic [3:0] set_flags;
    logic       sticky_clr;
    logic [3:0] cond;
    logic [3:0] e_flags;
    logic       e_st;
    logic [7:0] e_cnt;
    logic [1:0] e_cnt2;
    logic       e_ct;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic av, logic [3:0] ctl, logic [3:0] f,
                              logic sv, logic [3:0] sf, logic clr, logic [3:0] cc,
                              logic [3:0] ef, logic est, logic [7:0] ec,
                              logic [1:0] ec2, logic ect);
    vec_t v;
    v.rst_n = r; v.alu_valid = av; v.control = ctl; v.nzcv = f;
    v.set_valid = sv; v.set_flags = sf; v.sticky_clr = clr; v.cond = cc;
    v.e_flags = ef; v.e_st = est; v.e_cnt = ec; v.e_cnt2 = ec2; v.e_ct = ect;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic check_all(input int idx, input logic [3:0] ef, input logic est,
                           input logic [7:0] ec, input logic [1:0] ec2, input logic ect);
    chk("flags",      idx, {4'b0, flags_a}, {4'b0, ef});
    chk("v_sticky",   idx, {7'b0, st_a},    {7'b0, est});
    chk("ovf_count",  idx, cnt_a,           ec);
    chk("cond_true",  idx, {7'b0, ct_a},    {7'b0, ect});
    chk("flags_w2",   idx, {4'b0, flags_b}, {4'b0, ef});
    chk("sticky_w2",  idx, {7'b0, st_b},    {7'b0, est});
    chk("count_w2",   idx, {6'b0, cnt_b},   {6'b0, ec2});
    chk("cond_w2",    idx, {7'b0, ct_b},    {7'b0, ect});
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; alu_valid = v.alu_valid; control = v.control; nzcv = v.nzcv;
    set_valid = v.set_valid; set_flags = v.set_flags; sticky_clr = v.sticky_clr;
    cond = v.cond;
  endtask

  initial begin
    //            rst av ctl      nzcv     sv sf       clr cond    | flags   st cnt cnt2 ct
    vecs[0]  = mk(0, 1, 4'b1000, 4'b0001, 0, 4'b0000, 0, 4'b1110, 4'b0000, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 4'b1000, 4'b1001, 0, 4'b0000, 0, 4'b0110, 4'b1001, 1, 1, 1, 1);
    vecs[2]  = mk(1, 1, 4'b0010, 4'b0111, 0, 4'b0000, 0, 4'b0000, 4'b0101, 1, 1, 1, 1);
    vecs[3]  = mk(1, 1, 4'b1001, 4'b1111, 1, 4'b0010, 0, 4'b0010, 4'b0010, 1, 1, 1, 1);
    vecs[4]  = mk(1, 1, 4'b1001, 4'b0001, 0, 4'b0000, 0, 4'b1010, 4'b0001, 1, 2, 2, 0);
    vecs[5]  = mk(1, 1, 4'b1000, 4'b0011, 0, 4'b0000, 0, 4'b1011, 4'b0011, 1, 3, 3, 1);
    vecs[6]  = mk(1, 1, 4'b1000, 4'b1001, 0, 4'b0000, 0, 4'b1100, 4'b1001, 1, 4, 3, 1);
    vecs[7]  = mk(1, 1, 4'b1000, 4'b0101, 0, 4'b0000, 0, 4'b1101, 4'b0101, 1, 5, 3, 1);
    vecs[8]  = mk(1, 1, 4'b1000, 4'b0001, 0, 4'b0000, 1, 4'b1111, 4'b0001, 1, 1, 1, 0);
    vecs[9]  = mk(1, 0, 4'b1000, 4'b1111, 0, 4'b0000, 1, 4'b0111, 4'b0001, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, 4'b1000, 4'b0000, 0, 4'b0000, 0, 4'b0001, 4'b0000, 0, 0, 0, 1);
    vecs[11] = mk(1, 0, 4'b0000, 4'b1111, 0, 4'b0000, 0, 4'b0011, 4'b0000, 0, 0, 0, 1);
    vecs[12] = mk(1, 0, 4'b0000, 4'b0000, 1, 4'b0001, 0, 4'b0110, 4'b0001, 0, 0, 0, 1);
    vecs[13] = mk(1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b1000, 4'b0001, 0, 0, 0, 0);
    vecs[14] = mk(1, 0, 4'b0000, 4'b0000, 1, 4'b0110, 0, 4'b1001, 4'b0110, 0, 0, 0, 1);
    vecs[15] = mk(1, 0, 4'b0000, 4'b0000, 1, 4'b1000, 0, 4'b0100, 4'b1000, 0, 0, 0, 1);
    vecs[16] = mk(1, 0, 4'b0000, 4'b0000, 1, 4'b1000, 0, 4'b0101, 4'b1000, 0, 0, 0, 0);
    vecs[17] = mk(1, 0, 4'b0000, 4'b0000, 1, 4'b1110, 0, 4'b1000, 4'b1110, 0, 0, 0, 0);
    vecs[18] = mk(1, 0, 4'b0000, 4'b0000, 1, 4'b0010, 0, 4'b1000, 4'b0010, 0, 0, 0, 1);
    vecs[19] = mk(1, 0, 4'b0000, 4'b0000, 1, 4'b0100, 0, 4'b0011, 4'b0100, 0, 0, 0, 1);
    vecs[20] = mk(1, 1, 4'b1010, 4'b1011, 0, 4'b0000, 0, 4'b1011, 4'b1000, 0, 0, 0, 1);
    vecs[21] = mk(1, 1, 4'b1000, 4'b0001, 0, 4'b0000, 0, 4'b1110, 4'b0001, 1, 1, 1, 1);
    vecs[22] = mk(0, 1, 4'b1000, 4'b0001, 1, 4'b1111, 0, 4'b1110, 4'b0000, 0, 0, 0, 0);

    drive(vecs[0]);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_all(i, vecs[i].e_flags, vecs[i].e_st, vecs[i].e_cnt, vecs[i].e_cnt2,
                vecs[i].e_ct);
    end

    // Five back-to-back add overflows: wide counter climbs, narrow one pins at 3.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive(mk(1, 1, 4'b1000, 4'b1001, 0, 4'b0000, 0, 4'b1011, 4'b0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check_all(100 + k, 4'b1001, 1'b1, 8'(k), (k >= 3) ? 2'd3 : 2'(k), 1'b0);
    end

    // Clear with no event, then hold with nothing valid.
    @(negedge clk);
    drive(mk(1, 0, 4'b1000, 4'b1111, 0, 4'b0000, 1, 4'b0110, 4'b0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_all(200, 4'b1001, 1'b0, 8'd0, 2'd0, 1'b1);
    @(negedge clk);
    drive(mk(1, 0, 4'b1000, 4'b0000, 0, 4'b0000, 0, 4'b0100, 4'b0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_all(201, 4'b1001, 1'b0, 8'd0, 2'd0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
